dlv4_sync: RTL and testbench

DLV4_SYNC -- requirements
Module: dlv4_sync

---
 rtl/dlv4_pkg.sv | 17 +
 rtl/dlv4_slice_dly.sv | 45 ++++
 rtl/dlv4_sync.sv | 75 +++++++
 tb/tb_dlv4_sync.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dlv4_pkg.sv
// Shared constants and types for the 4-way diagonal interleave link
// (common to the dlv4 receiver and the ilv4 transmitter).
package dlv4_pkg;

  localparam int NUM_LANES = 4;
  localparam int PCNT_W    = 2;

  typedef logic [PCNT_W-1:0] pcnt_t;

  // Number of valid words that must be absorbed before the lines are full.
  localparam pcnt_t PCNT_FULL = pcnt_t'(NUM_LANES - 1);

  function automatic pcnt_t pcnt_sat_inc(input pcnt_t p);
    return (p == PCNT_FULL) ? p : p + pcnt_t'(1);
  endfunction

endpackage

// File: rtl/dlv4_slice_dly.sv
// One lane of the de-interleaver: a Q-bit shift delay of DEPTH valid words,
// advancing only when en_i is high. DEPTH=0 is a plain wire.
module dlv4_slice_dly
  import dlv4_pkg::*;
#(
  parameter int Q     = 4,
  parameter int DEPTH = 0
) (
  input  logic         clk_i,
  input  logic         srst_i,
  input  logic         en_i,
  input  logic [Q-1:0] din_i,
  output logic [Q-1:0] dout_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = ^{clk_i, srst_i, en_i};
    assign dout_o    = din_i;
  end else begin : g_shift
    logic [Q-1:0] sr_q [DEPTH];
    logic [Q-1:0] sr_d [DEPTH];

    always_comb begin
      sr_d = sr_q;
      if (en_i) begin
        sr_d[0] = din_i;
        for (int i = 1; i < DEPTH; i++) begin
          sr_d[i] = sr_q[i-1];
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (srst_i) begin
        sr_q <= '{default: '0};
      end else begin
        sr_q <= sr_d;
      end
    end

    assign dout_o = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/dlv4_sync.sv
// 4-way diagonal de-interleaver: lane k of the line word is delayed by
// (3-k) valid words so every output word is re-aligned from one source word.
module dlv4_sync
  import dlv4_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             flush,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             primed
);

  localparam int Q = WIDTH / NUM_LANES;

  // Handshake: there is no backpressure. din is consumed on every edge that
  // samples din_valid=1; dout is meaningful only in cycles where
  // dout_valid=1 and otherwise holds its last delivered word.

  logic [WIDTH-1:0] aligned;
  pcnt_t            pcnt_q, pcnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    dlv4_slice_dly #(
      .Q     (Q),
      .DEPTH (NUM_LANES - 1 - k)
    ) u_dly (
      .clk_i  (clk),
      .srst_i (srst),
      .en_i   (din_valid),
      .din_i  (din[k*Q +: Q]),
      .dout_o (aligned[k*Q +: Q])
    );
  end

  // A word arriving with flush still enters the lines and counts as the
  // first word of the new priming run.
  always_comb begin
    pcnt_d       = pcnt_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    if (flush) begin
      pcnt_d = din_valid ? pcnt_t'(1) : pcnt_t'(0);
    end else if (din_valid) begin
      if (pcnt_q == PCNT_FULL) begin
        dout_d       = aligned;
        dout_valid_d = 1'b1;
      end
      pcnt_d = pcnt_sat_inc(pcnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      pcnt_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign primed     = (pcnt_q == PCNT_FULL);

endmodule

// File: tb/tb_dlv4_sync.sv
// Bench for dlv4_sync: a reference 4-way diagonal interleaver builds line
// words from a source stream; a forked monitor checks every delivered word.
module tb_dlv4_sync;

  localparam int WIDTH = 16;
  localparam int Q     = WIDTH / 4;

  logic             clk = 1'b0;
  logic             srst;
  logic             flush;
  logic             din_valid;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             primed;

  dlv4_sync #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .srst       (srst),
    .flush      (flush),
    .din_valid  (din_valid),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .primed     (primed)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  int               src_mode;
  logic [WIDTH-1:0] src_base;
  int               single_idx;
  int               m;
  int               fresh;
  int               pulses;
  int               f_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // source stream: counter from src_base, or a single 000F word at single_idx
  function automatic logic [WIDTH-1:0] src_word(input int j);
    if (j < 0) return '0;
    if (src_mode == 0) return src_base + WIDTH'(j);
    return (j == single_idx) ? WIDTH'(16'h000F) : '0;
  endfunction

  // reference ilv4: slice k of line n carries slice k of source word n-k
  function automatic logic [WIDTH-1:0] line_word(input int n);
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] s;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      s = src_word(n - k);
      w[k*Q +: Q] = s[k*Q +: Q];
    end
    return w;
  endfunction

  task automatic restart(input int mode, input logic [WIDTH-1:0] base, input int sidx);
    src_mode   = mode;
    src_base   = base;
    single_idx = sidx;
    m          = 0;
    fresh      = 0;
  endtask

  // driver: one clock of stimulus; returns shortly after the sampling edge
  task automatic cycle(input logic v, input logic fl, input logic rs);
    @(negedge clk);
    srst      = rs;
    flush     = fl;
    din_valid = v;
    din       = v ? line_word(m) : WIDTH'($urandom);
    if (rs) begin
      fresh = 0;
    end else begin
      if (v && !fl && fresh == 3) exp_q.push_back(src_word(m - 3));
      if (fl) fresh = v ? 1 : 0;
      else if (v && fresh < 3) fresh++;
      if (v) m++;
    end
    @(posedge clk);
    #2;
  endtask

  // scoreboard monitor
  task automatic monitor();
    logic [WIDTH-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (dout_valid === 1'b1) begin
        pulses++;
        if (dout == WIDTH'(16'h000F)) f_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_dout actual=%0h required=none", dout);
        end else begin
          e = exp_q.pop_front();
          if (dout !== e) begin
            errors++;
            $display("FAIL dout_data actual=%0h required=%0h", dout, e);
          end
        end
      end
    end
  endtask

  initial begin
    logic             v;
    logic [WIDTH-1:0] prev;
    int               nvalid;
    int               p0;

    srst = 1'b1; flush = 1'b0; din_valid = 1'b0; din = '0;
    pulses = 0; f_seen = 0;
    restart(0, '0, 0);
    fork monitor(); join_none

    // reset state
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_primed", primed, 0);

    // gap-free loopback from counter 0
    for (int i = 0; i < 1200; i++) begin
      cycle(1, 0, 0);
      if (i == 1) check("prime_w2", primed, 0);
      if (i == 2) begin
        check("prime_w3", primed, 1);
        check("dv_w3", dout_valid, 0);
      end
      if (i == 3) begin
        check("dv_w4", dout_valid, 1);
        check("first_dout", dout, 16'h0000);
      end
      if (i == 4) check("second_dout", dout, 16'h0001);
      if (i == 5) check("third_dout", dout, 16'h0002);
    end

    // flush pulse mid-stream
    cycle(0, 1, 0);
    check("flush_dv", dout_valid, 0);
    check("flush_primed", primed, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(1, 0, 0);
      if (i < 3) check("flush_dv_low", dout_valid, 0);
      if (i == 3) check("flush_dv_back", dout_valid, 1);
    end

    // flush and valid together
    cycle(1, 1, 0);
    check("fv_primed0", primed, 0);
    check("fv_dv", dout_valid, 0);
    cycle(1, 0, 0);
    check("fv_primed1", primed, 0);
    cycle(1, 0, 0);
    check("fv_primed2", primed, 1);
    cycle(1, 0, 0);
    check("fv_dv_back", dout_valid, 1);

    // one-cycle reset mid-stream, then restarted source at 0A00
    cycle(0, 0, 1);
    check("mid_rst_dout", dout, 0);
    check("mid_rst_dv", dout_valid, 0);
    check("mid_rst_primed", primed, 0);
    restart(0, 16'h0A00, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 0);
      if (i < 3) check("rst_dv_low", dout_valid, 0);
      if (i == 3) begin
        check("rst_dv_back", dout_valid, 1);
        check("rst_first_dout", dout, 16'h0A00);
      end
    end

    // random 50% gaps from a fresh start
    cycle(0, 0, 1);
    restart(0, 16'h2000, 0);
    p0 = pulses;
    nvalid = 0;
    for (int i = 0; i < 400; i++) begin
      v = 1'($urandom_range(0, 1));
      prev = dout;
      cycle(v, 0, 0);
      if (v) nvalid++;
      else begin
        check("gap_dv", dout_valid, 0);
        check("gap_hold", dout, prev);
      end
    end
    check("gap_pulses", pulses - p0, nvalid - 3);

    // single-slice word at source index 5
    cycle(0, 0, 1);
    restart(1, '0, 5);
    f_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1, 0, 0);
      if (i == 8) check("single_dout", dout, 16'h000F);
      if (i == 9) check("single_after", dout, 16'h0000);
    end
    check("single_count", f_seen, 1);

    for (int i = 0; i < 3; i++) cycle(0, 0, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
